// File: rtl/rgb_pwm_gen.sv
// Three-channel 8-bit PWM generator for the SB_RGBA_DRV inputs.
// Commands are applied glitch-free at period wrap, either immediately or as a linear fade.
package rgb_pwm_pkg;
    typedef struct packed {
        logic [1:0] chan;
        logic [7:0] level;
        logic       fade;
    } cmd_t;
endpackage

module rgb_pwm_lane (
    input  logic       gclk,
    input  logic       grst_n,
    input  logic       wrap,
    input  logic       step,
    input  logic       wr,
    input  logic [7:0] wr_level,
    input  logic       wr_fade,
    input  logic [7:0] phase_nxt,
    output logic       pwm,
    output logic       busy_nxt
);
    logic [7:0] level, target, active;
    logic [7:0] level_nxt, target_nxt, active_nxt;

    // A command on this lane takes priority over a fade step on the same wrap.
    always_comb begin
        level_nxt  = level;
        target_nxt = target;
        if (wr) begin
            target_nxt = wr_level;
            if (!wr_fade) level_nxt = wr_level;
        end else if (wrap && step) begin
            if (level < target)      level_nxt = level + 8'd1;
            else if (level > target) level_nxt = level - 8'd1;
        end
    end

    assign active_nxt = wrap ? level_nxt : active;
    assign busy_nxt   = (level_nxt != target_nxt);

    // Compare against next-state phase/duty so the output register shows
    // the first step of the new period right after the wrap edge.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            level  <= '0;
            target <= '0;
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            level  <= level_nxt;
            target <= target_nxt;
            active <= active_nxt;
            pwm    <= (phase_nxt < active_nxt);
        end
    end
endmodule

module rgb_pwm_gen #(
    parameter int PRESCALE = 47,
    parameter int FADE_DIV = 3
) (
    input  logic       CLK12,
    input  logic       RSTn,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [1:0] CMD_CHAN,
    input  logic [7:0] CMD_LEVEL,
    input  logic       CMD_FADE,
    output logic       RGB0PWM,
    output logic       RGB1PWM,
    output logic       RGB2PWM,
    output logic       BUSY,
    output logic       PERIOD_START
);
    import rgb_pwm_pkg::*;

    localparam int NUM_LANES = 3;
    localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam int FW = (FADE_DIV > 0) ? $clog2(FADE_DIV + 1) : 1;

    logic [PW-1:0]          presc;
    logic [FW-1:0]          fcnt;
    logic [7:0]             phase, phase_nxt;
    logic                   tick, wrap, step;
    cmd_t                   pend;
    logic                   pend_vld;
    logic [NUM_LANES-1:0]   wr, pwm, busy_nxt;

    assign tick      = (presc == PW'(PRESCALE));
    assign wrap      = tick && (phase == 8'hFF);
    assign step      = (fcnt == FW'(FADE_DIV));
    assign phase_nxt = tick ? phase + 8'd1 : phase;
    assign CMD_READY = !pend_vld;

    always_ff @(posedge CLK12 or negedge RSTn) begin
        if (!RSTn) begin
            presc        <= '0;
            phase        <= '0;
            fcnt         <= '0;
            pend         <= '0;
            pend_vld     <= 1'b0;
            BUSY         <= 1'b0;
            PERIOD_START <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            phase <= phase_nxt;
            if (wrap) fcnt <= step ? '0 : fcnt + FW'(1);
            // Slot is only ever filled while empty, so fill and drain never collide.
            if (CMD_VALID && CMD_READY) begin
                pend     <= '{chan: CMD_CHAN, level: CMD_LEVEL, fade: CMD_FADE};
                pend_vld <= 1'b1;
            end else if (wrap) begin
                pend_vld <= 1'b0;
            end
            BUSY         <= |busy_nxt;
            PERIOD_START <= wrap;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign wr[i] = wrap && pend_vld && (pend.chan == 2'd3 || pend.chan == 2'(i));
        rgb_pwm_lane u_lane (
            .gclk      (CLK12),
            .grst_n    (RSTn),
            .wrap      (wrap),
            .step      (step),
            .wr        (wr[i]),
            .wr_level  (pend.level),
            .wr_fade   (pend.fade),
            .phase_nxt (phase_nxt),
            .pwm       (pwm[i]),
            .busy_nxt  (busy_nxt[i])
        );
    end

    assign RGB0PWM = pwm[0];
    assign RGB1PWM = pwm[1];
    assign RGB2PWM = pwm[2];
endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Directed bench for rgb_pwm_gen with PRESCALE=0, FADE_DIV=0 (256-clock period, fade step every period).
module tb_rgb_pwm_gen;
    logic       CLK12 = 1'b0;
    logic       RSTn = 1'b1;
    logic       CMD_VALID = 1'b0;
    logic       CMD_READY;
    logic [1:0] CMD_CHAN = '0;
    logic [7:0] CMD_LEVEL = '0;
    logic       CMD_FADE = 1'b0;
    logic       RGB0PWM, RGB1PWM, RGB2PWM, BUSY, PERIOD_START;

    int n_chk = 0;
    int n_fail = 0;
    int hi_cnt[3];
    bit shape_ok[3];

    typedef struct {
        logic [1:0] chan;
        logic [7:0] level;
        int         e0, e1, e2;
    } vec_t;
    vec_t tbl[6];

    rgb_pwm_gen #(.PRESCALE(0), .FADE_DIV(0)) dut (
        .CLK12        (CLK12),
        .RSTn         (RSTn),
        .CMD_VALID    (CMD_VALID),
        .CMD_READY    (CMD_READY),
        .CMD_CHAN     (CMD_CHAN),
        .CMD_LEVEL    (CMD_LEVEL),
        .CMD_FADE     (CMD_FADE),
        .RGB0PWM      (RGB0PWM),
        .RGB1PWM      (RGB1PWM),
        .RGB2PWM      (RGB2PWM),
        .BUSY         (BUSY),
        .PERIOD_START (PERIOD_START)
    );

    always #5 CLK12 = ~CLK12;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at the negedge of the first cycle of a period; returns at the next period's first negedge.
    task automatic measure();
        bit seen_low[3];
        logic [2:0] p;
        for (int c = 0; c < 3; c++) begin
            hi_cnt[c] = 0; shape_ok[c] = 1'b1; seen_low[c] = 1'b0;
        end
        for (int k = 0; k < 256; k++) begin
            p = {RGB2PWM, RGB1PWM, RGB0PWM};
            for (int c = 0; c < 3; c++) begin
                if (p[c]) begin
                    hi_cnt[c]++;
                    if (seen_low[c]) shape_ok[c] = 1'b0;
                end else begin
                    seen_low[c] = 1'b1;
                end
            end
            @(negedge CLK12);
            CMD_VALID = 1'b0;
        end
    endtask

    task automatic chk_period(input string tag, input int e0, input int e1, input int e2, input int eb);
        chk({tag, "_pstart"}, PERIOD_START, 1);
        chk({tag, "_busy"}, BUSY, eb);
        measure();
        chk({tag, "_cnt0"}, hi_cnt[0], e0);
        chk({tag, "_cnt1"}, hi_cnt[1], e1);
        chk({tag, "_cnt2"}, hi_cnt[2], e2);
        for (int c = 0; c < 3; c++) chk({tag, "_shape"}, shape_ok[c], 1);
    endtask

    task automatic send(input string tag, input logic [1:0] ch, input logic [7:0] lvl, input logic fd);
        int n = 0;
        while (!CMD_READY && n < 1000) begin
            @(negedge CLK12); n++;
        end
        chk({tag, "_rdy_before"}, CMD_READY, 1);
        CMD_CHAN = ch; CMD_LEVEL = lvl; CMD_FADE = fd; CMD_VALID = 1'b1;
        @(posedge CLK12);
        @(negedge CLK12);
        CMD_VALID = 1'b0;
        chk({tag, "_rdy_after"}, CMD_READY, 0);
    endtask

    task automatic wait_apply(input string tag);
        int n = 0;
        while (!CMD_READY && n < 1000) begin
            @(negedge CLK12); n++;
        end
        chk({tag, "_rdy_back"}, CMD_READY, 1);
        chk({tag, "_apply_wrap"}, PERIOD_START, 1);
    endtask

    task automatic count_to_pstart(input string tag);
        int n = 0;
        do begin
            @(negedge CLK12); n++;
        end while (!PERIOD_START && n < 1000);
        chk(tag, n, 256);
    endtask

    initial begin
        tbl[0] = '{chan: 2'd0, level: 8'd64,  e0: 64, e1: 0,   e2: 0};
        tbl[1] = '{chan: 2'd1, level: 8'd255, e0: 64, e1: 255, e2: 0};
        tbl[2] = '{chan: 2'd1, level: 8'd0,   e0: 64, e1: 0,   e2: 0};
        tbl[3] = '{chan: 2'd3, level: 8'd17,  e0: 17, e1: 17,  e2: 17};
        tbl[4] = '{chan: 2'd2, level: 8'd1,   e0: 17, e1: 17,  e2: 1};
        tbl[5] = '{chan: 2'd0, level: 8'd0,   e0: 0,  e1: 17,  e2: 1};

        // Power-on reset
        #1 RSTn = 1'b0;
        #1;
        chk("rst_ready", CMD_READY, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_pwm0", RGB0PWM, 0);
        chk("rst_pstart", PERIOD_START, 0);
        repeat (3) @(negedge CLK12);
        RSTn = 1'b1;
        count_to_pstart("rst_first_pstart");
        chk_period("idle", 0, 0, 0, 0);

        // Immediate sets, including duty extremes
        for (int i = 0; i < 6; i++) begin
            send($sformatf("vec%0d", i), tbl[i].chan, tbl[i].level, 1'b0);
            wait_apply($sformatf("vec%0d", i));
            chk_period($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].e2, 0);
        end

        // Fade 0 -> 3 on all channels
        send("clr", 2'd3, 8'd0, 1'b0);
        wait_apply("clr");
        chk_period("clr", 0, 0, 0, 0);
        send("fade", 2'd3, 8'd3, 1'b1);
        wait_apply("fade");
        for (int p = 0; p < 4; p++)
            chk_period($sformatf("fade_p%0d", p), p, p, p, (p < 3) ? 1 : 0);
        chk_period("fade_hold", 3, 3, 3, 0);

        // Immediate command overrides a fade in progress
        send("ovr_fade", 2'd0, 8'd200, 1'b1);
        wait_apply("ovr_fade");
        chk_period("ovr_fade", 3, 3, 3, 1);
        send("ovr_set", 2'd0, 8'd10, 1'b0);
        wait_apply("ovr_set");
        chk_period("ovr_p0", 10, 3, 3, 0);
        chk_period("ovr_p1", 10, 3, 3, 0);

        // Back-to-back commands with CMD_VALID held
        CMD_CHAN = 2'd0; CMD_LEVEL = 8'd100; CMD_FADE = 1'b0; CMD_VALID = 1'b1;
        begin
            int n = 0;
            while (!CMD_READY && n < 1000) begin
                @(negedge CLK12); n++;
            end
            chk("hs_a_ready", CMD_READY, 1);
            @(posedge CLK12);
            @(negedge CLK12);
            CMD_LEVEL = 8'd30;
            chk("hs_b_blocked", CMD_READY, 0);
            n = 0;
            while (!CMD_READY && n < 1000) begin
                @(negedge CLK12); n++;
            end
            chk("hs_b_ready", CMD_READY, 1);
        end
        chk_period("hs_a", 100, 3, 3, 0);
        wait_apply("hs_b");
        chk_period("hs_b", 30, 3, 3, 0);

        // Asynchronous reset mid-period, mid-fade, with a command pending
        send("mr_set", 2'd0, 8'd128, 1'b0);
        wait_apply("mr_set");
        chk_period("mr_set", 128, 3, 3, 0);
        send("mr_fade", 2'd0, 8'd140, 1'b1);
        wait_apply("mr_fade");
        send("mr_pend", 2'd1, 8'd9, 1'b0);
        repeat (3) @(negedge CLK12);
        chk("mr_pre_pwm0", RGB0PWM, 1);
        chk("mr_pre_busy", BUSY, 1);
        chk("mr_pre_ready", CMD_READY, 0);
        #1 RSTn = 1'b0;
        #1;
        chk("mr_pwm0", RGB0PWM, 0);
        chk("mr_pwm1", RGB1PWM, 0);
        chk("mr_busy", BUSY, 0);
        chk("mr_ready", CMD_READY, 1);
        chk("mr_pstart", PERIOD_START, 0);
        @(negedge CLK12);
        RSTn = 1'b1;
        count_to_pstart("mr_first_pstart");
        chk_period("mr_after", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
